tile_pingpong_buffer: RTL and testbench

Double-banked (ping-pong) tile buffer for the systolic-array tiling path, the successor to the single-bank accelerator buffer. A loader fills one bank while the array drains the other, and the two banks swap ownership through a commit/release handshake, so tile load and compute overlap. Each bank keeps the registered 1-cycle read port and the zero-on-out-of-range read behaviour. The block adds bank ownership tracking, a read-valid strobe and an optional error flag.

---
 rtl/tile_pingpong_buffer.sv | 113 +++++++++++
 tb/tb_tile_pingpong_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tile_pingpong_buffer.sv
// Two-bank ping-pong tile buffer: the loader fills one bank while the array drains the other.
// Optional sticky protocol error flag is built when TILE_BUF_ERR_CHECK_EN is defined.
module tile_pingpong_buffer #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 20,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_commit,
    output logic                  o_wr_ready,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_rd_bank_ready,
    input  logic                  i_rd_release,
    output logic [1:0]            o_banks_full,
    output logic                  o_err
);

    logic [DATA_WIDTH-1:0] r_mem [2][DEPTH];
    logic [1:0]            r_full;
    logic [1:0]            w_fullNext;
    logic                  r_wrSel;
    logic                  r_rdSel;
    logic [DATA_WIDTH-1:0] r_rdData;
    logic                  r_rdValid;

    logic                  w_wrReady;
    logic                  w_rdReady;
    logic                  w_wrAddrOk;
    logic                  w_rdAddrOk;
    logic                  w_wrAccept;
    logic                  w_rdAccept;
    logic                  w_commit;
    logic                  w_release;
    logic [DATA_WIDTH-1:0] w_rdWord;

    assign w_wrReady  = ~r_full[r_wrSel];
    assign w_rdReady  = r_full[r_rdSel];
    assign w_wrAddrOk = 32'(i_wr_addr) < DEPTH;
    assign w_rdAddrOk = 32'(i_rd_addr) < DEPTH;
    assign w_wrAccept = i_wr_en & w_wrReady & w_wrAddrOk;
    assign w_rdAccept = i_rd_en & w_rdReady;
    assign w_commit   = i_wr_commit & w_wrReady;
    assign w_release  = i_rd_release & w_rdReady;
    assign w_rdWord   = w_rdAddrOk ? r_mem[r_rdSel][i_rd_addr] : '0;

    // Commit and release can never target the same bank in one cycle (one needs it empty, the other full).
    always_comb begin
        w_fullNext = r_full;
        if (w_commit)
            w_fullNext[r_wrSel] = 1'b1;
        if (w_release)
            w_fullNext[r_rdSel] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_wrAccept)
            r_mem[r_wrSel][i_wr_addr] <= i_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full    <= 2'b00;
            r_wrSel   <= 1'b0;
            r_rdSel   <= 1'b0;
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
        end else begin
            r_full    <= w_fullNext;
            r_rdValid <= w_rdAccept;
            if (w_commit)
                r_wrSel <= ~r_wrSel;
            if (w_release)
                r_rdSel <= ~r_rdSel;
            if (w_rdAccept)
                r_rdData <= w_rdWord;
        end
    end

`ifdef TILE_BUF_ERR_CHECK_EN
    logic r_err;
    logic w_errEvent;

    assign w_errEvent = (i_wr_en & (~w_wrReady | ~w_wrAddrOk))
                      | (i_rd_en & (~w_rdReady | ~w_rdAddrOk))
                      | (i_wr_commit & ~w_wrReady)
                      | (i_rd_release & ~w_rdReady);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err <= 1'b0;
        else
            r_err <= r_err | w_errEvent;
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_wr_ready      = w_wrReady;
    assign o_rd_bank_ready = w_rdReady;
    assign o_banks_full    = {1'b0, r_full[0]} + {1'b0, r_full[1]};
    assign o_rd_data       = r_rdData;
    assign o_rd_valid      = r_rdValid;

endmodule

// File: tb/tb_tile_pingpong_buffer.sv
// Directed bench for tile_pingpong_buffer: a bank-level behavioural model checked every cycle,
// plus hand-computed literal expectations along the fill/drain/swap/reset scenarios.
module tb_tile_pingpong_buffer;

    localparam int DW    = 128;
    localparam int DEPTH = 20;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          wrEn;
    logic [AW-1:0] wrAddr;
    logic [DW-1:0] wrData;
    logic          wrCommit;
    logic          wrReady;
    logic          rdEn;
    logic [AW-1:0] rdAddr;
    logic [DW-1:0] rdData;
    logic          rdValid;
    logic          rdBankReady;
    logic          rdRelease;
    logic [1:0]    banksFull;
    logic          err;

    tile_pingpong_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_wr_en         (wrEn),
        .i_wr_addr       (wrAddr),
        .i_wr_data       (wrData),
        .i_wr_commit     (wrCommit),
        .o_wr_ready      (wrReady),
        .i_rd_en         (rdEn),
        .i_rd_addr       (rdAddr),
        .o_rd_data       (rdData),
        .o_rd_valid      (rdValid),
        .o_rd_bank_ready (rdBankReady),
        .i_rd_release    (rdRelease),
        .o_banks_full    (banksFull),
        .o_err           (err)
    );

    always #5 clk = ~clk;

    // Model state: two banks of words, a full flag per bank, and which bank each side owns.
    logic [DW-1:0] mMem [2][DEPTH];
    bit   [1:0]    mFull;
    bit            mWrSel;
    bit            mRdSel;
    logic [DW-1:0] mRdData;
    bit            mRdValid;
    bit            mErr;

    int  errCount   = 0;
    int  checkCount = 0;
    bit  checkEn    = 1'b0;

    task automatic checkValue(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function void modelReset();
        mFull    = 2'b00;
        mWrSel   = 1'b0;
        mRdSel   = 1'b0;
        mRdData  = '0;
        mRdValid = 1'b0;
        mErr     = 1'b0;
    endfunction

    function void modelStep(input bit we, input int wa, input logic [DW-1:0] wd, input bit wc,
                            input bit re, input int ra, input bit rr);
        bit canWrite;
        bit canRead;
        canWrite = !mFull[mWrSel];
        canRead  = mFull[mRdSel];
`ifdef TILE_BUF_ERR_CHECK_EN
        if ((we && (!canWrite || wa >= DEPTH)) || (re && (!canRead || ra >= DEPTH)) ||
            (wc && !canWrite) || (rr && !canRead))
            mErr = 1'b1;
`endif
        if (re && canRead)
            mRdData = (ra < DEPTH) ? mMem[mRdSel][ra] : '0;
        mRdValid = re && canRead;
        if (we && canWrite && wa < DEPTH)
            mMem[mWrSel][wa] = wd;
        if (wc && canWrite) begin
            mFull[mWrSel] = 1'b1;
            mWrSel        = !mWrSel;
        end
        if (rr && canRead) begin
            mFull[mRdSel] = 1'b0;
            mRdSel        = !mRdSel;
        end
    endfunction

    task automatic checkOutput();
        checkValue("rd_valid",      DW'(rdValid),     DW'(mRdValid));
        checkValue("rd_data",       rdData,           mRdData);
        checkValue("wr_ready",      DW'(wrReady),     DW'(!mFull[mWrSel]));
        checkValue("rd_bank_ready", DW'(rdBankReady), DW'(mFull[mRdSel]));
        checkValue("banks_full",    DW'(banksFull),   DW'(int'(mFull[0]) + int'(mFull[1])));
        checkValue("err",           DW'(err),         DW'(mErr));
    endtask

    always @(negedge clk) begin
        if (checkEn)
            checkOutput();
    end

    task automatic applyStimulus(input bit we, input int wa, input logic [DW-1:0] wd, input bit wc,
                                 input bit re, input int ra, input bit rr);
        wrEn      = we;
        wrAddr    = AW'(wa);
        wrData    = wd;
        wrCommit  = wc;
        rdEn      = re;
        rdAddr    = AW'(ra);
        rdRelease = rr;
        @(posedge clk);
        modelStep(we, wa, wd, wc, re, ra, rr);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        wrEn = 1'b0; wrAddr = '0; wrData = '0; wrCommit = 1'b0;
        rdEn = 1'b0; rdAddr = '0; rdRelease = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++)
                mMem[b][a] = '0;
        modelReset();
        checkEn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkValue("reset wr_ready",      DW'(wrReady),     DW'(1));
        checkValue("reset rd_bank_ready", DW'(rdBankReady), DW'(0));
        checkValue("reset banks_full",    DW'(banksFull),   DW'(0));
        checkValue("reset rd_valid",      DW'(rdValid),     DW'(0));
        checkValue("reset rd_data",       rdData,           DW'(0));
        rst = 1'b0;
        applyStimulus(0, 0, '0, 0, 0, 0, 0);

        // Fill bank 0; the final write carries the commit in the same cycle.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1, i, DW'(i), i == DEPTH - 1, 0, 0, 0);
        checkValue("fill banks_full",    DW'(banksFull),   DW'(1));
        checkValue("fill rd_bank_ready", DW'(rdBankReady), DW'(1));
        checkValue("fill wr_ready",      DW'(wrReady),     DW'(1));

        // Drain bank 0 while loading bank 1 with 100+i.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, i, DW'(100 + i), i == DEPTH - 1, 1, i, 0);
            checkValue("bank0 rd_data",  rdData,       DW'(i));
            checkValue("bank0 rd_valid", DW'(rdValid), DW'(1));
        end
        checkValue("overlap banks_full", DW'(banksFull), DW'(2));
        checkValue("overlap wr_ready",   DW'(wrReady),   DW'(0));

        applyStimulus(1, 3, DW'(32'hDEAD), 0, 0, 0, 0);
`ifdef TILE_BUF_ERR_CHECK_EN
        checkValue("overflow err", DW'(err), DW'(1));
`else
        checkValue("overflow err", DW'(err), DW'(0));
`endif

        applyStimulus(0, 0, '0, 0, 1, 25, 0);
        checkValue("oor rd_data",  rdData,       DW'(0));
        checkValue("oor rd_valid", DW'(rdValid), DW'(1));

        // Read from the bank being released in the same cycle.
        applyStimulus(0, 0, '0, 0, 1, 7, 1);
        checkValue("release rd_data",       rdData,           DW'(7));
        checkValue("release wr_ready",      DW'(wrReady),     DW'(1));
        checkValue("release rd_bank_ready", DW'(rdBankReady), DW'(1));
        checkValue("release banks_full",    DW'(banksFull),   DW'(1));

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(i == 0, 25, DW'(32'hBEEF), 0, 1, i, 0);
            checkValue("bank1 rd_data", rdData, DW'(100 + i));
        end

        // Commit bank 0 and release bank 1 together.
        applyStimulus(0, 0, '0, 1, 0, 0, 1);
        checkValue("swap banks_full",    DW'(banksFull),   DW'(1));
        checkValue("swap rd_bank_ready", DW'(rdBankReady), DW'(1));
        checkValue("swap wr_ready",      DW'(wrReady),     DW'(1));
        applyStimulus(0, 0, '0, 0, 1, 3, 0);
        checkValue("unchanged word", rdData, DW'(3));

        applyStimulus(0, 0, '0, 0, 0, 0, 1);
        applyStimulus(0, 0, '0, 0, 1, 5, 0);
        checkValue("not ready rd_valid", DW'(rdValid), DW'(0));
        checkValue("not ready rd_data",  rdData,       DW'(3));

        applyStimulus(0, 0, '0, 1, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 1, 0, 0);
        applyStimulus(0, 0, '0, 0, 1, 1, 0);
        checkValue("burst rd_data", rdData, DW'(101));

        // Asynchronous reset in the middle of a read burst.
        rdEn   = 1'b1;
        rdAddr = AW'(2);
        #3;
        rst = 1'b1;
        modelReset();
        #1;
        checkValue("async rd_valid",      DW'(rdValid),     DW'(0));
        checkValue("async rd_data",       rdData,           DW'(0));
        checkValue("async wr_ready",      DW'(wrReady),     DW'(1));
        checkValue("async banks_full",    DW'(banksFull),   DW'(0));
        checkValue("async rd_bank_ready", DW'(rdBankReady), DW'(0));
        rdEn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(0, 0, '0, 0, 0, 0, 0);

        applyStimulus(1, 0, DW'(55), 1, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 1, 0, 0);
        checkValue("post-reset rd_data", rdData, DW'(55));
        applyStimulus(0, 0, '0, 0, 0, 0, 0);

        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
